// File: rtl/fb_pkg.sv
// Shared types and default window geometry for the render frame buffer controller.
package fb_pkg;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } rend_state_t;

    typedef logic [23:0] pixel_t;

    localparam int DEF_START_X = 260;
    localparam int DEF_START_Y = 195;
    localparam int DEF_END_X   = 390;
    localparam int DEF_END_Y   = 295;
    localparam int DEF_ADDR_W  = 15;

endpackage

// File: rtl/fb_addr_calc.sv
// Window test and linear RAM address for one buffer; shared by the write and read sides.
module fb_addr_calc
    import fb_pkg::*;
#(
    parameter int START_X = DEF_START_X,
    parameter int START_Y = DEF_START_Y,
    parameter int END_X   = DEF_END_X,
    parameter int END_Y   = DEF_END_Y,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              buf_sel,
    output logic              in_window,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [31:0] SX = 32'(START_X);
    localparam logic [31:0] SY = 32'(START_Y);
    localparam logic [31:0] EX = 32'(END_X);
    localparam logic [31:0] EY = 32'(END_Y);
    localparam logic [31:0] W  = EX - SX;
    localparam logic [31:0] FB = W * (EY - SY);

    logic [31:0] h_s;
    logic [31:0] v_s;

    // Window decode and base + row-major offset; address forced to 0 outside.
    always_comb begin
        h_s       = {21'd0, hcount};
        v_s       = {22'd0, vcount};
        in_window = (h_s >= SX) && (h_s < EX) && (v_s >= SY) && (v_s < EY);
        if (in_window) begin
            addr = ADDR_W'((h_s - SX) + (v_s - SY) * W + (buf_sel ? FB : 32'd0));
        end else begin
            addr = '0;
        end
    end

endmodule

// File: rtl/render_frame_buffer_ctrl.sv
// Double-buffered frame store controller: fills the back buffer from the renderer
// and swaps to it on the display's new-frame pulse only once a whole frame is in.
module render_frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int START_X = DEF_START_X,
    parameter int START_Y = DEF_START_Y,
    parameter int END_X   = DEF_END_X,
    parameter int END_Y   = DEF_END_Y,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  pixel_t            pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output pixel_t            wr_data_out,
    output logic              wr_en_out,
    input  logic [10:0]       hcount_vga_in,
    input  logic [9:0]        vcount_vga_in,
    input  logic              nf_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              in_region_out,
    output logic              front_buf_out,
    output logic              frame_done_out,
    output logic [15:0]       frames_out,
    output logic [15:0]       dropped_out
);

    rend_state_t       state_r;
    logic              run_r;
    logic              front_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    pixel_t            wr_data_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              in_region_r;
    logic              frame_done_r;
    logic [15:0]       frames_r;
    logic [15:0]       dropped_r;

    logic              tready_s;
    logic              accept_s;
    logic              last_s;
    logic              wr_in_win_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              rd_in_win_s;
    logic [ADDR_W-1:0] rd_addr_s;

    fb_addr_calc #(
        .START_X(START_X), .START_Y(START_Y), .END_X(END_X), .END_Y(END_Y), .ADDR_W(ADDR_W)
    ) u_wr_calc (
        .hcount   (hcount_in),
        .vcount   (vcount_in),
        .buf_sel  (~front_r),
        .in_window(wr_in_win_s),
        .addr     (wr_addr_s)
    );

    fb_addr_calc #(
        .START_X(START_X), .START_Y(START_Y), .END_X(END_X), .END_Y(END_Y), .ADDR_W(ADDR_W)
    ) u_rd_calc (
        .hcount   (hcount_vga_in),
        .vcount   (vcount_vga_in),
        .buf_sel  (front_r),
        .in_window(rd_in_win_s),
        .addr     (rd_addr_s)
    );

    // Handshake decode; run_r keeps tready low while reset is (or was just) asserted.
    always_comb begin
        tready_s = run_r && (state_r == FILL);
        accept_s = pixel_axis_tvalid && tready_s;
        last_s   = accept_s && (hcount_in == 11'(END_X - 1)) && (vcount_in == 10'(END_Y - 1));
    end

    // Frame state machine, write port, counters and display read address.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= FILL;
            run_r        <= 1'b0;
            front_r      <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= 24'd0;
            rd_addr_r    <= '0;
            in_region_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frames_r     <= 16'd0;
            dropped_r    <= 16'd0;
        end else begin
            run_r        <= 1'b1;
            frame_done_r <= 1'b0;
            wr_en_r      <= accept_s && wr_in_win_s;
            if (accept_s && wr_in_win_s) begin
                wr_addr_r <= wr_addr_s;
                wr_data_r <= pixel_axis_tdata;
            end
            if (accept_s && !wr_in_win_s && (dropped_r != 16'hFFFF)) begin
                dropped_r <= dropped_r + 16'd1;
            end
            // A last pixel arriving with nf_in still lands in FILL, so that pulse cannot swap.
            case (state_r)
                FILL: begin
                    if (last_s) begin
                        state_r <= WAIT_SWAP;
                    end else begin
                        state_r <= FILL;
                    end
                end
                WAIT_SWAP: begin
                    if (nf_in) begin
                        state_r      <= FILL;
                        front_r      <= ~front_r;
                        frame_done_r <= 1'b1;
                        frames_r     <= frames_r + 16'd1;
                    end else begin
                        state_r <= WAIT_SWAP;
                    end
                end
                default: state_r <= FILL;
            endcase
            in_region_r <= rd_in_win_s;
            rd_addr_r   <= rd_addr_s;
        end
    end

    assign pixel_axis_tready = tready_s;
    assign wr_addr_out       = wr_addr_r;
    assign wr_data_out       = wr_data_r;
    assign wr_en_out         = wr_en_r;
    assign rd_addr_out       = rd_addr_r;
    assign in_region_out     = in_region_r;
    assign front_buf_out     = front_r;
    assign frame_done_out    = frame_done_r;
    assign frames_out        = frames_r;
    assign dropped_out       = dropped_r;

endmodule

// File: tb/tb_render_frame_buffer_ctrl.sv
// Directed self-checking bench for render_frame_buffer_ctrl with default window.
module tb_render_frame_buffer_ctrl;

    localparam int AW = 15;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [23:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          wr_en;
    logic [10:0]   hcount_vga;
    logic [9:0]    vcount_vga;
    logic          nf;
    logic [AW-1:0] rd_addr;
    logic          in_region;
    logic          front_buf;
    logic          frame_done;
    logic [15:0]   frames;
    logic [15:0]   dropped;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 aclk = ~aclk;

    render_frame_buffer_ctrl dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .pixel_axis_tdata (tdata),
        .pixel_axis_tvalid(tvalid),
        .pixel_axis_tready(tready),
        .hcount_in        (hcount),
        .vcount_in        (vcount),
        .wr_addr_out      (wr_addr),
        .wr_data_out      (wr_data),
        .wr_en_out        (wr_en),
        .hcount_vga_in    (hcount_vga),
        .vcount_vga_in    (vcount_vga),
        .nf_in            (nf),
        .rd_addr_out      (rd_addr),
        .in_region_out    (in_region),
        .front_buf_out    (front_buf),
        .frame_done_out   (frame_done),
        .frames_out       (frames),
        .dropped_out      (dropped)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [10:0] h, input logic [9:0] v);
        return {h, v, 3'b101};
    endfunction

    // One clock: drive at negedge, note acceptance, return 1 time unit after posedge.
    task automatic cyc(input logic vld, input logic [10:0] h, input logic [9:0] v,
                       input logic nfp, output logic acc);
        @(negedge aclk);
        tvalid = vld;
        hcount = h;
        vcount = v;
        tdata  = pix(h, v);
        nf     = nfp;
        #1;
        acc = vld & tready;
        @(posedge aclk);
        #1;
        tvalid = 1'b0;
        nf     = 1'b0;
    endtask

    task automatic rd(input logic [10:0] h, input logic [9:0] v);
        @(negedge aclk);
        hcount_vga = h;
        vcount_vga = v;
        @(posedge aclk);
        #1;
    endtask

    // Raster stream of npix pixels from the window origin; checks every write.
    task automatic stream(input int npix, input bit gaps, input int base,
                          output int nwr, output int nerr, output int first_a, output int last_a);
        logic        acc;
        logic [10:0] h;
        logic [9:0]  v;
        int          exp_a;
        nwr = 0; nerr = 0; first_a = -1; last_a = -1;
        for (int i = 0; i < npix; i++) begin
            h = 11'(260 + i % 130);
            v = 10'(195 + i / 130);
            exp_a = base + i;
            if (gaps && $urandom_range(0, 3) == 0) begin
                cyc(1'b0, h, v, 1'b0, acc);
                if (wr_en !== 1'b0) nerr++;
            end
            cyc(1'b1, h, v, 1'b0, acc);
            if (!acc) begin
                nerr++;
            end else if (wr_en !== 1'b1 || int'(wr_addr) != exp_a || wr_data !== pix(h, v)) begin
                nerr++;
            end else begin
                nwr++;
                if (first_a < 0) first_a = int'(wr_addr);
                last_a = int'(wr_addr);
            end
        end
    endtask

    initial begin
        logic acc;
        int   nwr, nerr, fa, la, wcnt;

        aresetn = 1'b0; tvalid = 1'b0; tdata = 24'd0; hcount = 11'd0; vcount = 10'd0;
        hcount_vga = 11'd0; vcount_vga = 10'd0; nf = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_tready", 32'(tready), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_front", 32'(front_buf), 32'd0);
        check_val("rst_frames", 32'(frames), 32'd0);
        check_val("rst_dropped", 32'(dropped), 32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);
        check_val("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_val("rst_in_region", 32'(in_region), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        check_val("run_tready", 32'(tready), 32'd1);

        // Full first frame into back buffer 1.
        stream(13000, 1'b0, 13000, nwr, nerr, fa, la);
        check_val("f1_writes", 32'(nwr), 32'd13000);
        check_val("f1_errors", 32'(nerr), 32'd0);
        check_val("f1_first_addr", 32'(fa), 32'd13000);
        check_val("f1_last_addr", 32'(la), 32'd25999);
        check_val("f1_tready_wait", 32'(tready), 32'd0);
        check_val("f1_front", 32'(front_buf), 32'd0);
        cyc(1'b1, 11'd260, 10'd195, 1'b0, acc);
        check_val("wait_no_accept", 32'(acc), 32'd0);
        check_val("wait_no_write", 32'(wr_en), 32'd0);
        check_val("wait_no_drop", 32'(dropped), 32'd0);

        // Swap on new-frame pulse.
        cyc(1'b0, 11'd0, 10'd0, 1'b1, acc);
        check_val("swap1_done", 32'(frame_done), 32'd1);
        check_val("swap1_front", 32'(front_buf), 32'd1);
        check_val("swap1_frames", 32'(frames), 32'd1);
        check_val("swap1_tready", 32'(tready), 32'd1);
        cyc(1'b0, 11'd0, 10'd0, 1'b0, acc);
        check_val("swap1_done_pulse", 32'(frame_done), 32'd0);

        // Display reads from front buffer 1.
        rd(11'd260, 10'd195);
        check_val("rd_origin_addr", 32'(rd_addr), 32'd13000);
        check_val("rd_origin_in", 32'(in_region), 32'd1);
        rd(11'd259, 10'd195);
        check_val("rd_left_addr", 32'(rd_addr), 32'd0);
        check_val("rd_left_in", 32'(in_region), 32'd0);
        rd(11'd389, 10'd294);
        check_val("rd_corner_addr", 32'(rd_addr), 32'd25999);
        rd(11'd260, 10'd295);
        check_val("rd_below_in", 32'(in_region), 32'd0);

        // New-frame pulse while filling must not swap.
        cyc(1'b0, 11'd0, 10'd0, 1'b1, acc);
        check_val("fill_nf_done", 32'(frame_done), 32'd0);
        check_val("fill_nf_front", 32'(front_buf), 32'd1);

        // Partial second frame with gaps into buffer 0, then last pixel coincident with nf.
        stream(390, 1'b1, 0, nwr, nerr, fa, la);
        check_val("f2_writes", 32'(nwr), 32'd390);
        check_val("f2_errors", 32'(nerr), 32'd0);
        check_val("f2_first_addr", 32'(fa), 32'd0);
        check_val("f2_last_addr", 32'(la), 32'd389);
        cyc(1'b1, 11'd389, 10'd294, 1'b1, acc);
        check_val("f2_last_acc", 32'(acc), 32'd1);
        check_val("f2_last_addr12999", 32'(wr_addr), 32'd12999);
        check_val("f2_same_nf_done", 32'(frame_done), 32'd0);
        check_val("f2_same_nf_front", 32'(front_buf), 32'd1);
        check_val("f2_tready_wait", 32'(tready), 32'd0);
        cyc(1'b0, 11'd0, 10'd0, 1'b1, acc);
        check_val("swap2_done", 32'(frame_done), 32'd1);
        check_val("swap2_front", 32'(front_buf), 32'd0);
        check_val("swap2_frames", 32'(frames), 32'd2);
        rd(11'd261, 10'd196);
        check_val("rd_front0_addr", 32'(rd_addr), 32'd131);

        // Out-of-window pixels and drop saturation.
        cyc(1'b1, 11'd100, 10'd50, 1'b0, acc);
        check_val("drop_no_write", 32'(wr_en), 32'd0);
        check_val("drop_one", 32'(dropped), 32'd1);
        wcnt = 0;
        for (int i = 0; i < 65533; i++) begin
            cyc(1'b1, 11'd100, 10'd50, 1'b0, acc);
            if (wr_en) wcnt++;
        end
        check_val("drop_fffe", 32'(dropped), 32'hFFFE);
        cyc(1'b1, 11'd100, 10'd50, 1'b0, acc);
        check_val("drop_ffff", 32'(dropped), 32'hFFFF);
        cyc(1'b1, 11'd100, 10'd50, 1'b0, acc);
        check_val("drop_sat", 32'(dropped), 32'hFFFF);
        check_val("drop_writes", 32'(wcnt), 32'd0);

        // Reset mid-frame discards the partial back buffer.
        stream(500, 1'b0, 13000, nwr, nerr, fa, la);
        check_val("f3_errors", 32'(nerr), 32'd0);
        check_val("f3_last_addr", 32'(la), 32'd13499);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_val("mid_rst_addr", 32'(wr_addr), 32'd0);
        check_val("mid_rst_frames", 32'(frames), 32'd0);
        check_val("mid_rst_dropped", 32'(dropped), 32'd0);
        check_val("mid_rst_front", 32'(front_buf), 32'd0);
        check_val("mid_rst_tready", 32'(tready), 32'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        stream(3, 1'b0, 13000, nwr, nerr, fa, la);
        check_val("refill_first_addr", 32'(fa), 32'd13000);
        check_val("refill_writes", 32'(nwr), 32'd3);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
